mac_accum: RTL

//   Accumulator stage directly downstream of the two-lane pipelined multiplier (main).

---
 rtl/mac_accum_if.sv | 26 ++
 rtl/mac_accum.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mac_accum_if.sv
// Product-in / result-out bundle between the two-lane multiplier and mac_accum.
interface mac_accum_if #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 64
);
    logic                        go_T;
    logic signed [WIDTH-1:0]     in0;
    logic                        in0_v;
    logic signed [WIDTH-1:0]     in1;
    logic                        in1_v;
    logic signed [ACC_WIDTH-1:0] sum;
    logic                        done_T;
    logic                        busy;
    logic                        err;
    logic                        sat;

    modport master (
        output go_T, in0, in0_v, in1, in1_v,
        input  sum, done_T, busy, err, sat
    );

    modport slave (
        input  go_T, in0, in0_v, in1, in1_v,
        output sum, done_T, busy, err, sat
    );
endinterface

// File: rtl/mac_accum.sv
// Two-lane signed accumulator: sums LEN products per go_T and pulses done_T with the result.
// Define MAC_ACCUM_SAT_EN for saturating additions; otherwise additions wrap.
module mac_accum #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 64,
    parameter int LEN       = 4
) (
    input logic        clk,
    input logic        reset,
    mac_accum_if.slave bus
);
    localparam int            CW    = $clog2(LEN + 1);
    localparam logic [CW-1:0] LEN_C = CW'(LEN);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        err_q, err_d;
    logic                        sat_q, sat_d;
    logic                        accept;
    logic                        complete;
    logic [ACC_WIDTH:0]          add0, add1;

    function automatic logic signed [ACC_WIDTH-1:0] ext(input logic signed [WIDTH-1:0] x);
        return ACC_WIDTH'(x);
    endfunction

    // Returns {clamped, result}; the clamp bit is only ever set in the saturating build.
    function automatic logic [ACC_WIDTH:0] acc_add(input logic signed [ACC_WIDTH-1:0] a,
                                                   input logic signed [ACC_WIDTH-1:0] b);
        logic signed [ACC_WIDTH-1:0] s;
        s = a + b;
`ifdef MAC_ACCUM_SAT_EN
        if ((a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != a[ACC_WIDTH-1])) begin
            return a[ACC_WIDTH-1] ? {1'b1, 1'b1, {(ACC_WIDTH-1){1'b0}}}
                                  : {1'b1, 1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
`endif
        return {1'b0, s};
    endfunction

    always_comb begin
        acc_d    = acc_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        sat_d    = sat_q;
        add0     = '0;
        add1     = '0;
        complete = 1'b0;
        accept   = bus.go_T || (state_q == ACCUM);
        if (bus.go_T) begin
            acc_d = '0;
            sum_d = '0;
            cnt_d = '0;
            err_d = 1'b0;
            sat_d = 1'b0;
        end
        if (accept) begin
            if (bus.in0_v) begin
                add0  = acc_add(acc_d, ext(bus.in0));
                acc_d = add0[ACC_WIDTH-1:0];
                sat_d = sat_d | add0[ACC_WIDTH];
                cnt_d = cnt_d + CW'(1);
            end
            // in1 arriving after in0 already completed the run is dropped
            if (bus.in1_v) begin
                if (cnt_d == LEN_C) begin
                    err_d = 1'b1;
                end else begin
                    add1  = acc_add(acc_d, ext(bus.in1));
                    acc_d = add1[ACC_WIDTH-1:0];
                    sat_d = sat_d | add1[ACC_WIDTH];
                    cnt_d = cnt_d + CW'(1);
                end
            end
            complete = (cnt_d == LEN_C);
            if (complete) begin
                sum_d = acc_d;
            end
        end else if (bus.in0_v || bus.in1_v) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (complete) begin
            state_d = DONE;
        end else if (accept) begin
            state_d = ACCUM;
        end else begin
            state_d = IDLE;
        end
    end

    always_comb begin
        bus.sum    = sum_q;
        bus.done_T = (state_q == DONE);
        bus.busy   = (state_q == ACCUM);
        bus.err    = err_q;
        bus.sat    = sat_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            sum_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sum_q <= sum_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            sat_q <= sat_d;
        end
    end
endmodule
